apb2ahb_bridge: RTL and testbench



---
 rtl/ahb_apb_pkg.sv | 25 ++
 rtl/apb2ahb_strb_decode.sv | 33 +++
 rtl/apb2ahb_bridge.sv | 152 +++++++++++++++
 tb/tb_apb2ahb_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB bridge encodings
// Purpose: HTRANS/HSIZE/HBURST codes, default HPROT, and the bridge FSM state type.
// Ports: none (package).
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } bridge_state_t;

endpackage

// File: rtl/apb2ahb_strb_decode.sv
// rtl/apb2ahb_strb_decode.sv - APB4 byte-strobe to AHB size/offset decoder
// Purpose: maps a 4-bit PSTRB onto an AHB transfer size and byte-lane offset.
// Ports:
//   pstrb   in  4  APB write strobes
//   hsize   out 3  AHB transfer size
//   offset  out 2  low address bits for the transfer
//   illegal out 1  strobe pattern has no single-transfer AHB equivalent
module apb2ahb_strb_decode
  import ahb_apb_pkg::*;
(
  input  logic [3:0] pstrb,
  output logic [2:0] hsize,
  output logic [1:0] offset,
  output logic       illegal
);

  always_comb begin
    hsize   = HSIZE_WORD;
    offset  = 2'b00;
    illegal = 1'b0;
    case (pstrb)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; offset = 2'b10; end
      4'b0001: begin hsize = HSIZE_BYTE; offset = 2'b00; end
      4'b0010: begin hsize = HSIZE_BYTE; offset = 2'b01; end
      4'b0100: begin hsize = HSIZE_BYTE; offset = 2'b10; end
      4'b1000: begin hsize = HSIZE_BYTE; offset = 2'b11; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb2ahb_bridge.sv
// rtl/apb2ahb_bridge.sv - APB3 completer to AHB-Lite manager bridge
// Purpose: turns each APB access into one SINGLE AHB transfer and returns
//   HRDATA/HRESP through PRDATA/PSLVERR, stretching the access with PREADY.
//   Optional macro APB4_EN adds PSTRB/PPROT (sized transfers, HPROT mapping).
// Ports:
//   HCLK, HRESETn                     clock, async active-low reset
//   PSEL, PENABLE, PADDR, PWRITE,     APB completer inputs
//   PWDATA, (PSTRB, PPROT)
//   PRDATA, PREADY, PSLVERR           APB completer outputs (registered)
//   HADDR, HTRANS, HWRITE, HSIZE,     AHB-Lite manager outputs (registered)
//   HBURST, HPROT, HWDATA
//   HRDATA, HREADY, HRESP             AHB-Lite manager inputs
module apb2ahb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int                    ADDRWIDTH  = 16,
  parameter int                    DATAWIDTH  = 32,
  parameter int                    HADDRWIDTH = 32,
  parameter logic [HADDRWIDTH-1:0] AHB_BASE   = 32'h4000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDRWIDTH-1:0]  PADDR,
  input  logic                  PWRITE,
  input  logic [DATAWIDTH-1:0]  PWDATA,
  output logic [DATAWIDTH-1:0]  PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [HADDRWIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATAWIDTH-1:0]  HWDATA,
  input  logic [DATAWIDTH-1:0]  HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
`ifdef APB4_EN
  ,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT
`endif
);

  bridge_state_t state;
  logic          abort;    // PSEL dropped mid-transfer: finish AHB side, drop the result

  logic [2:0]            setup_size;
  logic [1:0]            setup_off;
  logic                  setup_bad;
  logic [3:0]            setup_prot;
  logic [HADDRWIDTH-1:0] setup_addr;

`ifdef APB4_EN
  logic [2:0] dec_size;
  logic [1:0] dec_off;
  logic       dec_illegal;

  apb2ahb_strb_decode u_strb_decode (
    .pstrb   (PSTRB),
    .hsize   (dec_size),
    .offset  (dec_off),
    .illegal (dec_illegal)
  );

  // Reads ignore the strobes and always fetch an aligned word.
  assign setup_size = PWRITE ? dec_size : HSIZE_WORD;
  assign setup_off  = PWRITE ? dec_off  : 2'b00;
  assign setup_bad  = PWRITE & dec_illegal;
  assign setup_prot = {2'b00, PPROT[0], ~PPROT[2]};
`else
  assign setup_size = HSIZE_WORD;
  assign setup_off  = PADDR[1:0];
  assign setup_bad  = 1'b0;
  assign setup_prot = HPROT_DEFAULT;
`endif

  assign setup_addr = ((AHB_BASE | HADDRWIDTH'(PADDR)) & ~HADDRWIDTH'(2'b11))
                    | HADDRWIDTH'(setup_off);

  assign HBURST = HBURST_SINGLE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      abort   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      HTRANS  <= HTRANS_IDLE;
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HWDATA  <= '0;
      HSIZE   <= HSIZE_WORD;
      HPROT   <= HPROT_DEFAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only a genuine setup phase starts an access; PSEL&PENABLE here is ignored.
          if (PSEL && !PENABLE) begin
            HADDR  <= setup_addr;
            HWRITE <= PWRITE;
            HWDATA <= PWDATA;
            HSIZE  <= setup_size;
            HPROT  <= setup_prot;
            abort  <= 1'b0;
            if (setup_bad) begin
              // Unrepresentable strobe pattern: answer with an error, no AHB traffic.
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              state   <= ST_DONE;
            end else begin
              HTRANS <= HTRANS_NONSEQ;
              state  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          abort <= abort | ~PSEL;
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          abort <= abort | ~PSEL;
          // HRESP is only meaningful with HREADY, so the first error cycle is waited out.
          if (HREADY) begin
            if (abort || !PSEL) begin
              state <= ST_IDLE;
            end else begin
              if (!HWRITE) PRDATA <= HRDATA;
              PSLVERR <= HRESP;
              PREADY  <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// tb/tb_apb2ahb_bridge.sv - self-checking bench for apb2ahb_bridge
module tb_apb2ahb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [15:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
`ifdef APB4_EN
  logic [3:0]  PSTRB = 4'hF;
  logic [2:0]  PPROT = 3'b000;
`endif

  apb2ahb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
`ifdef APB4_EN
    , .PSTRB(PSTRB), .PPROT(PPROT)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exp_haddr;
    logic [31:0] exp_prdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One APB access against a bench-side AHB slave. With drop_psel, PSEL falls
  // in the second access cycle and the access is watched for hold_cycles.
  task automatic run_xfer(input vec_t v, input bit drop_psel, input int hold_cycles);
    int          cyc, dp, nseq, lat;
    logic        got;
    logic [31:0] sa;
    logic        sw;
    vec_t        e;
    if (!drop_psel) exp_q.push_back(v);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = v.wr; PADDR = v.addr; PWDATA = v.wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    check("setup_pready", {31'b0, PREADY}, 32'd0);
    check("setup_htrans", {30'b0, HTRANS}, 32'd0);
    cyc = 0; dp = -1; nseq = 0; got = 1'b0; lat = 0; sa = '0; sw = 1'b0;
    while (cyc < 40 && !got && !(drop_psel && cyc >= hold_cycles)) begin
      @(posedge HCLK); #1;
      cyc++;
      PENABLE = 1'b1;
      if (drop_psel && cyc >= 2) PSEL = 1'b0;
      if (dp >= 0) begin
        if (v.err && dp == v.waits - 1) begin HREADY = 1'b0; HRESP = 1'b1; end
        else if (dp < v.waits)          begin HREADY = 1'b0; HRESP = 1'b0; end
        else begin HREADY = 1'b1; HRESP = v.err; HRDATA = v.rdata; end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0_BAD0;
      end
      @(negedge HCLK);
      if (dp >= 0) begin
        if (HREADY) begin
          if (v.wr) check("hwdata", HWDATA, v.wdata);
          dp = -1;
        end else dp++;
      end
      if (HTRANS == 2'b10) begin
        nseq++; sa = HADDR; sw = HWRITE;
        if (HREADY) dp = 0;
      end
      if (PREADY) begin got = 1'b1; lat = cyc; end
    end
    if (!drop_psel) begin
      e = exp_q.pop_front();
      check("pready_seen", {31'b0, got}, 32'd1);
      if (got) begin
        check("latency", 32'(lat), 32'(e.exp_lat));
        check("prdata", PRDATA, e.exp_prdata);
        check("pslverr", {31'b0, PSLVERR}, {31'b0, e.exp_err});
        check("nonseq_count", 32'(nseq), 32'd1);
        check("haddr", sa, e.exp_haddr);
        check("hwrite", {31'b0, sw}, {31'b0, e.wr});
      end
    end else begin
      check("drop_no_pready", {31'b0, got}, 32'd0);
      check("drop_nonseq_count", 32'(nseq), 32'd1);
      check("drop_prdata", PRDATA, v.exp_prdata);
    end
  endtask

  initial begin
    vec_t vd;
    vec_t vn;
    logic seen_bad;

    vecs[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         32'h4000_0010, 32'h0,         1'b0, 3};
    vecs[1] = '{1'b0, 16'h0020, 32'h0,         2, 1'b0, 32'h1234_5678, 32'h4000_0020, 32'h1234_5678, 1'b0, 5};
    vecs[2] = '{1'b0, 16'h0024, 32'h0,         1, 1'b1, 32'hCAFE_F00D, 32'h4000_0024, 32'hCAFE_F00D, 1'b1, 4};
    vecs[3] = '{1'b1, 16'h0030, 32'h1122_3344, 1, 1'b0, 32'h0,         32'h4000_0030, 32'hCAFE_F00D, 1'b0, 4};
    vecs[4] = '{1'b0, 16'hFFFC, 32'h0,         0, 1'b0, 32'hA5A5_5A5A, 32'h4000_FFFC, 32'hA5A5_5A5A, 1'b0, 3};
    vecs[5] = '{1'b1, 16'h0100, 32'h0BAD_CAFE, 1, 1'b1, 32'h0,         32'h4000_0100, 32'hA5A5_5A5A, 1'b1, 4};

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    check("rst_htrans", {30'b0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hsize", {29'b0, HSIZE}, 32'd2);
    check("rst_hprot", {28'b0, HPROT}, 32'd3);
    check("rst_hburst", {29'b0, HBURST}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Back-to-back table vectors
    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0, 0);

    // PSEL & PENABLE without a setup phase must be ignored
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1;
    seen_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 || PREADY) seen_bad = 1'b1;
      @(posedge HCLK); #1;
    end
    check("no_setup_ignored", {31'b0, seen_bad}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;

    // PSEL dropped mid-transfer: AHB side completes, no PREADY, PRDATA untouched
    vd = '{1'b0, 16'h0050, 32'h0, 0, 1'b0, 32'h7777_7777, 32'h4000_0050, 32'hA5A5_5A5A, 1'b0, 0};
    run_xfer(vd, 1'b1, 6);
    vn = '{1'b1, 16'h0060, 32'h55AA_55AA, 0, 1'b0, 32'h0, 32'h4000_0060, 32'hA5A5_5A5A, 1'b0, 3};
    run_xfer(vn, 1'b0, 0);

    // Asynchronous reset during the data phase
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0040; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    @(negedge HCLK);
    check("pre_rst_haddr", HADDR, 32'h4000_0040);
    #1 HRESETn = 1'b0;
    #1;
    check("async_rst_htrans", {30'b0, HTRANS}, 32'd0);
    check("async_rst_pready", {31'b0, PREADY}, 32'd0);
    check("async_rst_haddr", HADDR, 32'h0);
    check("async_rst_prdata", PRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    vn = '{1'b1, 16'h0070, 32'h0F0F_0F0F, 0, 1'b0, 32'h0, 32'h4000_0070, 32'h0, 1'b0, 3};
    run_xfer(vn, 1'b0, 0);

`ifdef APB4_EN
    // Byte write via strobe 0100, then an unrepresentable strobe pattern
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0010; PSTRB = 4'b0100; HREADY = 1'b1;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    check("apb4_byte_nonseq", {30'b0, HTRANS}, 32'd2);
    check("apb4_byte_hsize", {29'b0, HSIZE}, 32'd0);
    check("apb4_byte_off", {30'b0, HADDR[1:0]}, 32'd2);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check("apb4_byte_pready", {31'b0, PREADY}, 32'd1);
    @(posedge HCLK); #1;
    PENABLE = 1'b0; PSTRB = 4'b0101;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    check("apb4_bad_htrans", {30'b0, HTRANS}, 32'd0);
    check("apb4_bad_pready", {31'b0, PREADY}, 32'd1);
    check("apb4_bad_pslverr", {31'b0, PSLVERR}, 32'd1);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PSTRB = 4'hF;
`endif

    repeat (2) @(posedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
